fir_sig_check: RTL



---
 rtl/fir_test_pkg.sv | 8 +
 rtl/fir_sig_check_if.sv | 15 +
 rtl/misr_step.sv | 11 +
 rtl/fir_sig_check.sv | 77 +++++++
 4 files changed

// File: rtl/fir_test_pkg.sv
// fir_test_pkg: shared FIR self-test cadence, MISR constants and FSM states
package fir_test_pkg;
  typedef enum logic [1:0] {RUN, CMP, DONE} state_t;
  localparam int FIR_TEST_PERIOD = 31;
  localparam int FIR_TEST_SAMPLE_AT = 30;
  localparam logic [31:0] FIR_MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] FIR_MISR_SEED = 32'hFFFFFFFF;
endpackage

// File: rtl/fir_sig_check_if.sv
// fir_sig_check_if: FIR sample in, signature/status out; FIR_SIG_CHECK_LOOP_EN adds fail_sticky
interface fir_sig_check_if #(parameter int DATA_W = 32);
  logic [DATA_W-1:0] outData;
  logic [DATA_W-1:0] sig;
  logic done;
  logic pass;
`ifdef FIR_SIG_CHECK_LOOP_EN
  logic fail_sticky;
  modport master (output outData, input sig, done, pass, fail_sticky);
  modport slave (input outData, output sig, done, pass, fail_sticky);
`else
  modport master (output outData, input sig, done, pass);
  modport slave (input outData, output sig, done, pass);
`endif
endinterface

// File: rtl/misr_step.sv
// misr_step: one Galois MISR step folding a data word into the signature
module misr_step #(
  parameter int DATA_W = 32,
  parameter logic [DATA_W-1:0] POLY = 32'h04C11DB7
) (
  input  logic [DATA_W-1:0] sig,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] sig_next
);
  assign sig_next = {sig[DATA_W-2:0], 1'b0} ^ (sig[DATA_W-1] ? POLY : '0) ^ data;
endmodule

// File: rtl/fir_sig_check.sv
// fir_sig_check: samples FIR output once per vector into a MISR and checks the final signature
// FIR_SIG_CHECK_LOOP_EN: rerun continuously and add a sticky failure flag
module fir_sig_check
  import fir_test_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PERIOD = FIR_TEST_PERIOD,
  parameter int SAMPLE_AT = FIR_TEST_SAMPLE_AT,
  parameter int NUM_VECTORS = 16,
  parameter logic [DATA_W-1:0] SIG_SEED = FIR_MISR_SEED,
  parameter logic [DATA_W-1:0] POLY = FIR_MISR_POLY,
  parameter logic [DATA_W-1:0] GOLDEN_SIG = '0
) (
  input logic clk,
  input logic rst,
  fir_sig_check_if.slave bus
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int SW = $clog2(NUM_VECTORS + 1);
`ifdef FIR_SIG_CHECK_LOOP_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scnt;
  logic [DATA_W-1:0] sig_q, sig_nx;
  logic done_q, pass_q, sample, last, run_cnt;
  misr_step #(.DATA_W(DATA_W), .POLY(POLY)) u_step (.sig(sig_q), .data(bus.outData), .sig_next(sig_nx));
  assign sample = (state == RUN) && (cnt == CW'(SAMPLE_AT));
  assign last = scnt == SW'(NUM_VECTORS - 1);
  // in loop mode the cadence must stay aligned with the stimulus controller across CMP/DONE
  assign run_cnt = LOOP || (state == RUN);
  always_comb begin
    state_nx = state;
    state_nx = (state == RUN) ? ((sample && last) ? CMP : RUN) :
               (state == CMP) ? DONE : (LOOP ? RUN : DONE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      scnt <= '0;
      sig_q <= SIG_SEED;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (run_cnt) cnt <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + 1'b1;
      if (sample) begin
        sig_q <= sig_nx;
        scnt <= scnt + 1'b1;
      end
      if (state == CMP) begin
        done_q <= 1'b1;
        pass_q <= sig_q == GOLDEN_SIG;
      end
      if (LOOP && state == DONE) begin
        sig_q <= SIG_SEED;
        scnt <= '0;
        done_q <= 1'b0;
      end
    end
  end
`ifdef FIR_SIG_CHECK_LOOP_EN
  logic fail_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fail_q <= 1'b0;
    else if (state == CMP && sig_q != GOLDEN_SIG) fail_q <= 1'b1;
  end
  assign bus.fail_sticky = fail_q;
`endif
  assign bus.sig = sig_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
endmodule
